// File: rtl/kim_panel_bridge_if.sv
// Host key-injection handshake for the KIM-1 front-panel bridge.
// Signals: key_code/key_valid (host -> bridge), key_ready/key_err (bridge -> host).
interface kim_panel_bridge_if;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_err;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready,
        input  key_err
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready,
        output key_err
    );
endinterface

// File: rtl/kim_panel_bridge.sv
// KIM-1 front-panel bridge: captures the scanned LED display into six digit
// registers and injects host key presses into the core's keypad column scan.
// Ports: clk, reset (async, active-high); LED_DIG/LED_SEG scanned display in;
// KB_ROW row scan in, phys_col physical keypad in, KB_COL merged columns out;
// digits/dig_valid/disp_upd display side; key (slave) host key handshake.
module kim_panel_bridge #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 100000,
    parameter int HOLD    = 50000,
    parameter int GAP     = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                LED_DIG,
    input  logic [6:0]                LED_SEG,
    input  logic [3:0]                KB_ROW,
    input  logic [6:0]                phys_col,
    output logic [6:0]                KB_COL,
    output logic [41:0]               digits,
    output logic [5:0]                dig_valid,
    output logic                      disp_upd,
    kim_panel_bridge_if.slave         key
);

    localparam int CW   = $clog2(SETTLE + 1);
    localparam int AW   = $clog2(TIMEOUT + 1);
    localparam int KMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int KW   = $clog2(KMAX + 1);

    localparam logic [CW-1:0] CNT_SAT  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_PRE  = (SETTLE >= 2) ? CW'(SETTLE - 2) : '0;
    localparam logic [AW-1:0] AGE_MAX  = AW'(TIMEOUT);
    localparam logic [AW-1:0] AGE_PRE  = AW'(TIMEOUT - 1);
    localparam logic [KW-1:0] HOLD_END = KW'(HOLD - 1);
    localparam logic [KW-1:0] GAP_END  = KW'(GAP - 1);

    // ---------------- display capture ----------------
    logic [5:0]    prev_dig;
    logic [6:0]    prev_seg;
    logic [CW-1:0] stable_cnt;
    logic [AW-1:0] age [6];

    logic [5:0] dig_n;
    logic       sel;
    logic       match;
    logic       cap;
    logic [2:0] sel_idx;
    logic [5:0] expire;

    assign dig_n = ~LED_DIG;
    assign sel   = (dig_n != 6'd0) && ((dig_n & (dig_n - 6'd1)) == 6'd0);
    assign match = sel && (LED_DIG == prev_dig) && (LED_SEG == prev_seg);

    // The write fires on the edge where the counter steps into saturation,
    // so a pattern held SETTLE cycles is captured exactly once.
    assign cap = (SETTLE == 1) ? (sel && !match)
                               : (match && (stable_cnt == CNT_PRE));

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!LED_DIG[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        expire = '0;
        for (int d = 0; d < 6; d++) begin
            expire[d] = (age[d] == AGE_PRE);
        end
    end

    // Ages reset to saturation so never-written digits do not
    // produce a spurious blanking pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_dig   <= '1;
            prev_seg   <= '1;
            stable_cnt <= '0;
            digits     <= '0;
            dig_valid  <= '0;
            disp_upd   <= 1'b0;
            for (int d = 0; d < 6; d++) begin
                age[d] <= AGE_MAX;
            end
        end else begin
            prev_dig <= LED_DIG;
            prev_seg <= LED_SEG;
            if (match) begin
                if (stable_cnt != CNT_SAT) stable_cnt <= stable_cnt + 1'b1;
            end else begin
                stable_cnt <= '0;
            end
            for (int d = 0; d < 6; d++) begin
                if (cap && (sel_idx == 3'(d))) begin
                    digits[7*d +: 7] <= ~LED_SEG;
                    dig_valid[d]     <= 1'b1;
                    age[d]           <= '0;
                end else if (expire[d]) begin
                    digits[7*d +: 7] <= '0;
                    dig_valid[d]     <= 1'b0;
                    age[d]           <= AGE_MAX;
                end else if (age[d] != AGE_MAX) begin
                    age[d] <= age[d] + 1'b1;
                end
            end
            disp_upd <= cap | (|expire);
        end
    end

    // ---------------- key injection ----------------
    typedef enum logic [1:0] {
        K_IDLE,
        K_PRESS,
        K_REL
    } kstate_t;

    kstate_t       kst;
    logic [KW-1:0] kcnt;
    logic [1:0]    row_q;
    logic [2:0]    col_q;
    logic          legal;
    logic [6:0]    inj_col;

    assign legal = (key.key_code[4:3] != 2'b11) && (key.key_code[2:0] != 3'b111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kst           <= K_IDLE;
            kcnt          <= '0;
            row_q         <= '0;
            col_q         <= '0;
            key.key_ready <= 1'b1;
            key.key_err   <= 1'b0;
        end else begin
            key.key_err <= 1'b0;
            unique case (kst)
                K_IDLE: begin
                    if (key.key_valid) begin
                        if (legal) begin
                            row_q         <= key.key_code[4:3];
                            col_q         <= key.key_code[2:0];
                            kcnt          <= '0;
                            kst           <= K_PRESS;
                            key.key_ready <= 1'b0;
                        end else begin
                            key.key_err <= 1'b1;
                        end
                    end
                end
                K_PRESS: begin
                    if (kcnt == HOLD_END) begin
                        kcnt <= '0;
                        kst  <= K_REL;
                    end else begin
                        kcnt <= kcnt + 1'b1;
                    end
                end
                K_REL: begin
                    if (kcnt == GAP_END) begin
                        kcnt          <= '0;
                        kst           <= K_IDLE;
                        key.key_ready <= 1'b1;
                    end else begin
                        kcnt <= kcnt + 1'b1;
                    end
                end
                default: begin
                    kst           <= K_IDLE;
                    key.key_ready <= 1'b1;
                end
            endcase
        end
    end

    // Combinational from the live row scan: the core reads columns
    // within one cycle of moving to a new row.
    always_comb begin
        inj_col = 7'h7F;
        if ((kst == K_PRESS) && !KB_ROW[row_q]) inj_col = ~(7'd1 << col_q);
    end

    assign KB_COL = phys_col & inj_col;

endmodule

// File: tb/tb_kim_panel_bridge.sv
// Self-checking bench for kim_panel_bridge: capture vector table with a
// disp_upd scoreboard, key injection table, and multi-cycle corner sequences.
module tb_kim_panel_bridge;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    localparam int HOLD    = 10;
    localparam int GAP     = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  LED_DIG = '1;
    logic [6:0]  LED_SEG = '1;
    logic [3:0]  KB_ROW = '1;
    logic [6:0]  phys_col = 7'h7F;
    logic [6:0]  KB_COL;
    logic [41:0] digits;
    logic [5:0]  dig_valid;
    logic        disp_upd;

    kim_panel_bridge_if kif();

    kim_panel_bridge #(
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT),
        .HOLD   (HOLD),
        .GAP    (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .LED_DIG  (LED_DIG),
        .LED_SEG  (LED_SEG),
        .KB_ROW   (KB_ROW),
        .phys_col (phys_col),
        .KB_COL   (KB_COL),
        .digits   (digits),
        .dig_valid(dig_valid),
        .disp_upd (disp_upd),
        .key      (kif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [5:0] dig;
        logic [6:0] seg;
        int         hold;
        bit         wr;
        int         idx;
        logic [6:0] exp;
    } cap_vec_t;

    typedef struct {
        logic [4:0] code;
        logic [3:0] row;
        logic [6:0] phys;
        logic [6:0] kbcol;
        bit         err;
    } key_vec_t;

    typedef struct {
        int         idx;
        logic [6:0] seg;
    } sb_t;

    sb_t sb[$];

    cap_vec_t cv [6];
    key_vec_t kv [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Every disp_upd pulse while monitoring must match a queued capture.
    always @(negedge clk) begin
        if (mon_en && !reset && disp_upd) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL disp_upd_unexpected: got pulse expected none at %0t", $time);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("cap_digit", 64'(digits[7*e.idx +: 7]), 64'(e.seg));
                chk("cap_valid", 64'(dig_valid[e.idx]), 64'd1);
            end
        end
    end

    logic [41:0] m_dig;
    logic [5:0]  m_val;
    int          cnt;
    int          lowcnt;

    initial begin
        cv[0] = '{6'b111110, 7'h06, 4,  1'b1, 0, 7'h79};
        cv[1] = '{6'b111011, 7'h5B, 5,  1'b1, 2, 7'h24};
        cv[2] = '{6'b110111, 7'h3F, 3,  1'b0, 3, 7'h00};
        cv[3] = '{6'b111100, 7'h06, 10, 1'b0, 0, 7'h00};
        cv[4] = '{6'b011111, 7'h00, 6,  1'b1, 5, 7'h7F};
        cv[5] = '{6'b111111, 7'h12, 5,  1'b0, 0, 7'h00};

        kv[0] = '{5'b01_011, 4'b1101, 7'h7F, 7'h77, 1'b0};
        kv[1] = '{5'b01_011, 4'b1101, 7'h7E, 7'h76, 1'b0};
        kv[2] = '{5'b01_011, 4'b1110, 7'h7F, 7'h7F, 1'b0};
        kv[3] = '{5'b00_110, 4'b1110, 7'h7F, 7'h3F, 1'b0};
        kv[4] = '{5'b10_000, 4'b1011, 7'h7F, 7'h7E, 1'b0};
        kv[5] = '{5'b11_000, 4'b0000, 7'h7F, 7'h7F, 1'b1};
        kv[6] = '{5'b00_111, 4'b0000, 7'h7F, 7'h7F, 1'b1};

        kif.key_code  = '0;
        kif.key_valid = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_digits", 64'(digits), 64'd0);
        chk("rst_valid", 64'(dig_valid), 64'd0);
        chk("rst_upd", 64'(disp_upd), 64'd0);
        chk("rst_ready", 64'(kif.key_ready), 64'd1);
        chk("rst_err", 64'(kif.key_err), 64'd0);
        phys_col = 7'h5A;
        #1 chk("rst_kbcol", 64'(KB_COL), 64'h5A);
        phys_col = 7'h7F;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // capture vector table
        mon_en = 1'b1;
        m_dig  = '0;
        m_val  = '0;
        foreach (cv[i]) begin
            if (cv[i].wr) begin
                sb.push_back('{cv[i].idx, cv[i].exp});
                m_dig[7*cv[i].idx +: 7] = cv[i].exp;
                m_val[cv[i].idx]        = 1'b1;
            end
            LED_DIG = cv[i].dig;
            LED_SEG = cv[i].seg;
            repeat (cv[i].hold) @(negedge clk);
            LED_DIG = '1;
            repeat (2) @(negedge clk);
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("table_digits", 64'(digits), 64'(m_dig));
        chk("table_valid", 64'(dig_valid), 64'(m_val));

        // segment pattern changing every 3 cycles never settles
        do_reset();
        LED_DIG = 6'b111110;
        for (int r = 0; r < 8; r++) begin
            LED_SEG = r[0] ? 7'h07 : 7'h06;
            repeat (3) @(negedge clk);
        end
        LED_DIG = '1;
        @(negedge clk);
        chk("toggle_no_write", 64'(dig_valid), 64'd0);
        chk("sb_toggle", 64'(sb.size()), 64'd0);

        // timeout blanking of digit 2
        mon_en = 1'b0;
        do_reset();
        LED_DIG = 6'b111011;
        LED_SEG = 7'h40;
        repeat (SETTLE) @(negedge clk);
        LED_DIG = '1;
        chk("to_capture_valid", 64'(dig_valid[2]), 64'd1);
        chk("to_capture_digit", 64'(digits[20:14]), 64'h3F);
        cnt = 0;
        while (dig_valid[2] && cnt < 80) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
        chk("timeout_digit", 64'(digits[20:14]), 64'd0);
        chk("timeout_pulse", 64'(disp_upd), 64'd1);
        @(negedge clk);
        chk("timeout_pulse_end", 64'(disp_upd), 64'd0);

        // key injection table
        do_reset();
        foreach (kv[i]) begin
            kif.key_code  = kv[i].code;
            kif.key_valid = 1'b1;
            @(negedge clk);
            kif.key_valid = 1'b0;
            if (kv[i].err) begin
                chk("key_err_pulse", 64'(kif.key_err), 64'd1);
                chk("key_ready_kept", 64'(kif.key_ready), 64'd1);
                KB_ROW   = kv[i].row;
                phys_col = kv[i].phys;
                #1 chk("kbcol_illegal", 64'(KB_COL), 64'(kv[i].kbcol));
                @(negedge clk);
                chk("key_err_clear", 64'(kif.key_err), 64'd0);
                KB_ROW   = '1;
                phys_col = 7'h7F;
            end else begin
                chk("key_no_err", 64'(kif.key_err), 64'd0);
                lowcnt = kif.key_ready ? 0 : 1;
                for (int c = 0; c < 40 && !kif.key_ready; c++) begin
                    if (lowcnt == 3) begin
                        KB_ROW   = kv[i].row;
                        phys_col = kv[i].phys;
                        #1 chk("kbcol_press", 64'(KB_COL), 64'(kv[i].kbcol));
                        KB_ROW = '1;
                        #1 chk("kbcol_unselected", 64'(KB_COL), 64'(kv[i].phys));
                        phys_col = 7'h7F;
                    end
                    if (lowcnt == 13) begin
                        KB_ROW = kv[i].row;
                        #1 chk("kbcol_release", 64'(KB_COL), 64'h7F);
                        KB_ROW = '1;
                    end
                    @(negedge clk);
                    if (!kif.key_ready) lowcnt++;
                end
                chk("key_busy_cycles", 64'(lowcnt), 64'(HOLD + GAP));
            end
            @(negedge clk);
        end

        // asynchronous reset in the middle of a press
        mon_en = 1'b1;
        sb.push_back('{0, 7'h79});
        LED_DIG = 6'b111110;
        LED_SEG = 7'h06;
        repeat (SETTLE) @(negedge clk);
        LED_DIG = '1;
        kif.key_code  = 5'b00_000;
        kif.key_valid = 1'b1;
        @(negedge clk);
        kif.key_valid = 1'b0;
        @(negedge clk);
        KB_ROW = 4'b1110;
        #1 chk("midpress_kbcol", 64'(KB_COL), 64'h7E);
        #1 reset = 1'b1;
        #1;
        chk("async_kbcol", 64'(KB_COL), 64'h7F);
        chk("async_ready", 64'(kif.key_ready), 64'd1);
        chk("async_digits", 64'(digits), 64'd0);
        chk("async_valid", 64'(dig_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("sb_final", 64'(sb.size()), 64'd0);
        @(negedge clk);
        chk("post_rst_kbcol", 64'(KB_COL), 64'h7F);
        chk("post_rst_ready", 64'(kif.key_ready), 64'd1);
        KB_ROW = '1;
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
